pipeline_barrier_hs: RTL and testbench
======================================

Name: pipeline_barrier_hs

Overview:
Parametrised, handshaked pipeline barrier that generalises the fixed MEM/WB-style register stage. It has a configurable payload width, valid/ready flow control with an optional 2-entry skid buffer, synchronous flush for hazard and branch squashing, and a saturating stall-cycle counter. It sits between any two pipeline stages. Upstream and downstream stage control signals travel packed inside the payload bus.

Parameters:
DATA_WIDTH, 66, payload width in bits (default carries 32b memory data, 32b execution data and 2 control bits).
SKID, 1, 1 = two-entry skid buffer with registered upReady; 0 = single register with combinational upReady.
CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
upValid  input  1  upstream payload valid.
upReady  output  1  barrier can accept a payload this cycle.
upData  input  DATA_WIDTH  upstream payload.
flush  input  1  discard all held payloads, synchronous.
downValid  output  1  downstream payload valid.
downReady  input  1  downstream accepts payload.
downData  output  DATA_WIDTH  downstream payload.
occupancy  output  2  number of payloads held (0..2; never exceeds 1 when SKID=0).
stallCount  output  CNT_WIDTH  cycles with downValid=1 and downReady=0, saturating.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-low. All state updates on the rising edge of `clk`.
- Reset (reset=0 at an edge):
  - mainValid=0, skidValid=0, main/skid data=0, stallCount=0.
  - While reset=0, upReady=0 and downValid=0.
- Transfers:
  - Upstream transfer occurs when upValid && upReady.
  - Downstream transfer occurs when downValid && downReady.
- Outputs:
  - downValid = mainValid. downData = main register.
  - occupancy = mainValid + skidValid.
- SKID=1, states EMPTY (0 held), ONE (main only), TWO (main+skid):
  - upReady = !skidValid, registered state only (no comb path from downReady).
  - EMPTY: up transfer -> ONE, main <= upData.
  - ONE:
    - up && down -> ONE, main <= upData.
    - up only -> TWO, skid <= upData.
    - down only -> EMPTY.
  - TWO:
    - upReady=0.
    - down -> ONE, main <= skid.
- SKID=0:
  - upReady = !mainValid || downReady (combinational).
  - EMPTY/ONE only; up && down in ONE replaces main.
- Ordering: strict FIFO order. No payload is duplicated or dropped except by flush.
- Stability: while downValid && !downReady, downData and downValid hold constant.
- Flush:
  - flush=1 at an edge clears mainValid and skidValid (-> EMPTY). Data registers need not be cleared.
  - Any upstream payload presented in the flush cycle is discarded, even if upReady=1.
  - A downstream transfer in the flush cycle still counts as completed.
  - flush has priority over all transitions. reset has priority over flush.
- Latency: one cycle from upstream transfer into EMPTY to downValid=1. Throughput is 1 payload/cycle when downReady=1 continuously.
- stallCount:
  - Increments by 1 on each edge where downValid && !downReady, sampled before update.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - Cleared only by reset, not by flush.
- Reset mid-operation: held payloads are lost and all outputs return to reset values on the same edge.

Test Plan:
- Reset and single pass (SKID=1, DATA_WIDTH=66): reset=0 for 2 cycles -> downValid=0, occupancy=0, stallCount=0. Release reset, upValid=1 with upData=0x3_DEADBEEF_00000001 for 1 cycle, downReady=1 -> next cycle downValid=1, downData=that value, then downValid=0.
- Back-pressure fill: downReady=0, send A=1, B=2, C=3 on consecutive cycles -> A and B accepted; occupancy 1 then 2; upReady=0 while C is held upstream. Then downReady=1 -> outputs A, B, C in order with no duplicates. stallCount equals the number of stalled cycles.
- Streaming: upValid=downReady=1 for 100 cycles with incrementing data -> 100 payloads emerge in order, one per cycle, latency 1, stallCount unchanged.
- Flush: occupancy=2 (A, B) plus upValid=1 with C, pulse flush=1 -> next cycle occupancy=0, downValid=0. C is never emitted; the next accepted payload D emerges normally.
- Saturation: CNT_WIDTH=4, downValid=1, downReady=0 for 20 cycles -> stallCount reaches 15 and holds.
- SKID=0 variant: downReady=0 with ONE held -> upReady=0 combinationally. Assert downReady=1 with upValid=1 in the same cycle -> main is replaced next cycle, occupancy never exceeds 1.

Source files
------------

// File: rtl/pipeline_barrier_hs.sv
// Handshaked pipeline barrier: valid/ready register stage with optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipeline_barrier_hs #(
  parameter int DATA_WIDTH = 66,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upValid,
  output logic                  upReady,
  input  logic [DATA_WIDTH-1:0] upData,
  input  logic                  flush,
  output logic                  downValid,
  input  logic                  downReady,
  output logic [DATA_WIDTH-1:0] downData,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stallCount
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_up;
  logic                  w_dn;
  logic                  w_stall;

  // Skid mode: ready depends only on registered state.
  always_comb begin
    upReady = 1'b0;
    if (SKID != 0) begin
      upReady = reset & (r_state != S_TWO);
    end else begin
      upReady = reset & ((r_state == S_EMPTY) | downReady);
    end
  end

  assign downValid  = reset & (r_state != S_EMPTY);
  assign downData   = r_main;
  assign occupancy  = r_state;
  assign stallCount = r_cnt;

  assign w_up    = upValid & upReady;
  assign w_dn    = downValid & downReady;
  assign w_stall = downValid & ~downReady;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      S_EMPTY: begin
        if (w_up) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = upData;
        end
      end
      S_ONE: begin
        if (w_up && w_dn) begin
          w_main_nxt = upData;
        end else if (w_up) begin
          w_state_nxt = S_TWO;
          w_skid_nxt  = upData;
        end else if (w_dn) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_dn) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipeline_barrier_hs.sv
// Bench for pipeline_barrier_hs: three configurations share one stimulus
// stream and are checked against a queue model every cycle.
module tb_pipeline_barrier_hs;

  logic        clk;
  logic        reset;
  logic        upValid;
  logic [65:0] upData;
  logic        flush;
  logic        downReady;

  logic        ur [3];
  logic        dv [3];
  logic [65:0] dd [3];
  logic [1:0]  occ [3];
  logic [15:0] sc0;
  logic [3:0]  sc1;
  logic [3:0]  sc2;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  pipeline_barrier_hs #(.DATA_WIDTH(66), .SKID(1), .CNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .upValid(upValid), .upReady(ur[0]),
    .upData(upData), .flush(flush), .downValid(dv[0]),
    .downReady(downReady), .downData(dd[0]), .occupancy(occ[0]),
    .stallCount(sc0));

  pipeline_barrier_hs #(.DATA_WIDTH(66), .SKID(1), .CNT_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .upValid(upValid), .upReady(ur[1]),
    .upData(upData), .flush(flush), .downValid(dv[1]),
    .downReady(downReady), .downData(dd[1]), .occupancy(occ[1]),
    .stallCount(sc1));

  pipeline_barrier_hs #(.DATA_WIDTH(66), .SKID(0), .CNT_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .upValid(upValid), .upReady(ur[2]),
    .upData(upData), .flush(flush), .downValid(dv[2]),
    .downReady(downReady), .downData(dd[2]), .occupancy(occ[2]),
    .stallCount(sc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: each barrier is a FIFO of capacity 2 (skid) or 1 (no skid).
  int          mn   [3];
  logic [65:0] mq   [3][2];
  int          mc   [3];
  int          cmax [3] = '{65535, 15, 15};
  bit          mskid[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    for (int k = 0; k < 3; k++) begin
      mn[k] = 0;
      mc[k] = 0;
      mq[k][0] = '0;
      mq[k][1] = '0;
    end
  end

  function automatic bit m_ur(int k);
    if (!reset) return 1'b0;
    if (mskid[k]) return (mn[k] < 2);
    return (mn[k] == 0) || downReady;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit up;
      bit dn;
      up = upValid && m_ur(k);
      dn = (mn[k] > 0) && downReady;
      if (!reset) begin
        mn[k] = 0;
        mc[k] = 0;
        mq[k][0] = '0;
      end else begin
        if ((mn[k] > 0) && !downReady && (mc[k] < cmax[k])) mc[k]++;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (dn) begin
            mq[k][0] = mq[k][1];
            mn[k]--;
          end
          if (up) begin
            mq[k][mn[k]] = upData;
            mn[k]++;
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [15:0] sc;
        sc = (k == 0) ? sc0 : ((k == 1) ? {12'd0, sc1} : {12'd0, sc2});
        chk($sformatf("m%0d.upReady", k), 128'(ur[k]), 128'(m_ur(k)));
        chk($sformatf("m%0d.downValid", k), 128'(dv[k]),
            128'(reset && (mn[k] > 0)));
        chk($sformatf("m%0d.occupancy", k), 128'(occ[k]), 128'(mn[k]));
        chk($sformatf("m%0d.stallCount", k), 128'(sc), 128'(mc[k]));
        if (mn[k] > 0) begin
          chk($sformatf("m%0d.downData", k), 128'(dd[k]), 128'(mq[k][0]));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [65:0] x1;
    x1 = 66'h3_DEADBEEF_00000001;
    reset = 1'b0;
    upValid = 1'b0;
    upData = '0;
    flush = 1'b0;
    downReady = 1'b0;
    cyc(2);
    chk("rst.downValid", 128'(dv[0]), 128'd0);
    chk("rst.occupancy", 128'(occ[0]), 128'd0);
    chk("rst.stallCount", 128'(sc0), 128'd0);
    chk("rst.upReady", 128'(ur[0]), 128'd0);
    chk("rst.downData", 128'(dd[0]), 128'd0);

    // single pass
    reset = 1'b1;
    upValid = 1'b1;
    upData = x1;
    downReady = 1'b1;
    #1;
    chk("pass.upReady", 128'(ur[0]), 128'd1);
    cyc(1);
    upValid = 1'b0;
    chk("pass.downValid", 128'(dv[0]), 128'd1);
    chk("pass.downData", 128'(dd[0]), 128'(x1));
    cyc(1);
    chk("pass.drain", 128'(dv[0]), 128'd0);

    // back-pressure fill
    downReady = 1'b0;
    upValid = 1'b1;
    upData = 66'd1;
    cyc(1);
    chk("bp.occ1", 128'(occ[0]), 128'd1);
    chk("bp.noskid.upReady", 128'(ur[2]), 128'd0);
    upData = 66'd2;
    cyc(1);
    chk("bp.occ2", 128'(occ[0]), 128'd2);
    chk("bp.headA", 128'(dd[0]), 128'd1);
    upData = 66'd3;
    cyc(1);
    chk("bp.upReady.full", 128'(ur[0]), 128'd0);
    cyc(1);
    chk("bp.occ.hold", 128'(occ[0]), 128'd2);
    chk("bp.stable", 128'(dd[0]), 128'd1);
    downReady = 1'b1;
    #1;
    chk("bp.noskid.combReady", 128'(ur[2]), 128'd1);
    cyc(1);
    chk("bp.outB", 128'(dd[0]), 128'd2);
    chk("bp.noskid.replace", 128'(dd[2]), 128'd3);
    chk("bp.noskid.occ", 128'(occ[2]), 128'd1);
    cyc(1);
    upValid = 1'b0;
    chk("bp.outC", 128'(dd[0]), 128'd3);
    cyc(1);
    chk("bp.empty", 128'(dv[0]), 128'd0);
    chk("bp.stallCount", 128'(sc0), 128'd3);

    // streaming
    upValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      upData = 66'(1000 + i);
      cyc(1);
      chk("stream.data", 128'(dd[0]), 128'(1000 + i));
    end
    upValid = 1'b0;
    cyc(1);
    chk("stream.drain", 128'(dv[0]), 128'd0);
    chk("stream.stallCount", 128'(sc0), 128'd3);

    // flush
    downReady = 1'b0;
    upValid = 1'b1;
    upData = 66'hA;
    cyc(1);
    upData = 66'hB;
    cyc(1);
    chk("fl.occ2", 128'(occ[0]), 128'd2);
    upData = 66'hC;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    upValid = 1'b0;
    chk("fl.occ0", 128'(occ[0]), 128'd0);
    chk("fl.downValid", 128'(dv[0]), 128'd0);
    upValid = 1'b1;
    upData = 66'hD;
    cyc(1);
    upValid = 1'b0;
    chk("fl.D.valid", 128'(dv[0]), 128'd1);
    chk("fl.D.data", 128'(dd[0]), 128'hD);
    downReady = 1'b1;
    cyc(1);
    chk("fl.D.drain", 128'(dv[0]), 128'd0);
    chk("fl.stallCount", 128'(sc0), 128'd5);

    // saturation
    downReady = 1'b0;
    upValid = 1'b1;
    upData = 66'h55;
    cyc(1);
    upValid = 1'b0;
    cyc(20);
    chk("sat.cnt16", 128'(sc0), 128'd25);
    chk("sat.cnt4.skid", 128'(sc1), 128'd15);
    chk("sat.cnt4.noskid", 128'(sc2), 128'd15);

    // reset mid-operation
    reset = 1'b0;
    cyc(1);
    chk("mrst.occ", 128'(occ[0]), 128'd0);
    chk("mrst.downValid", 128'(dv[0]), 128'd0);
    chk("mrst.stallCount", 128'(sc0), 128'd0);
    chk("mrst.downData", 128'(dd[0]), 128'd0);
    reset = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
